// File: rtl/acc_cpu_core_if.sv
// Load port of the accumulator CPU: valid/ready write channel into the
// instruction or data memory.
interface acc_cpu_core_if #(
    parameter int ADDR_W = 5
);
    localparam int INSTR_W = 3 + ADDR_W;

    logic               load_valid;
    logic               load_ready;
    logic               load_sel;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;

    modport master (
        output load_valid, load_sel, load_addr, load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid, load_sel, load_addr, load_data,
        output load_ready
    );
endinterface

// File: rtl/acc_cpu_core.sv
// Parametrised multi-cycle accumulator CPU with internal instruction/data
// memories, start/halt control, carry/zero flags and a retired counter.
//
// state  | meaning
// IDLE   | after reset; memories loadable, waiting for start
// FETCH  | ir <= imem[pc]
// EXEC   | execute ir, update pc/acc/dmem, count instruction
// HALTED | HLT executed; memories loadable, start reruns from pc 0
module acc_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    acc_cpu_core_if.slave      ld,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [ADDR_W-1:0]  pc,
    output logic [2+ADDR_W:0]  ir,
    output logic [DATA_W-1:0]  acc,
    output logic               carry,
    output logic               zero,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);
    localparam int INSTR_W = 3 + ADDR_W;
    localparam int DEPTH   = 2 ** ADDR_W;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

    state_t              state;
    logic                ready;
    logic [INSTR_W-1:0]  imem [DEPTH];
    logic [DATA_W-1:0]   dmem [DEPTH];
    logic [DATA_W-1:0]   load_word;
    logic                load_fire;
    logic [2:0]          opcode;
    logic [ADDR_W-1:0]   operand;
    logic [DATA_W-1:0]   mem_word;
    logic [DATA_W:0]     sum;

    generate
        if (DATA_W <= INSTR_W) begin : g_load_trunc
            assign load_word = ld.load_data[DATA_W-1:0];
        end else begin : g_load_ext
            assign load_word = {{(DATA_W-INSTR_W){1'b0}}, ld.load_data};
        end
    endgenerate

    assign ld.load_ready = ready;
    assign load_fire     = ld.load_valid && ready;
    assign opcode        = ir[INSTR_W-1:ADDR_W];
    assign operand       = ir[ADDR_W-1:0];
    assign mem_word      = dmem[operand];
    assign sum           = {1'b0, acc} + {1'b0, mem_word};
    assign zero          = (acc == '0);
    assign dbg_data      = dmem[dbg_addr];

    // Instruction memory keeps its contents across reset.
    always_ff @(posedge clock) begin
        if (load_fire && !ld.load_sel)
            imem[ld.load_addr] <= ld.load_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            halted  <= 1'b0;
            pc      <= '0;
            ir      <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            retired <= '0;
            for (int i = 0; i < DEPTH; i++)
                dmem[i] <= '0;
        end else begin
            if (load_fire && ld.load_sel)
                dmem[ld.load_addr] <= load_word;

            case (state)
                IDLE, HALTED: begin
                    // A load in the same cycle wins over start.
                    if (start && !load_fire) begin
                        state   <= FETCH;
                        pc      <= '0;
                        retired <= '0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        halted  <= 1'b0;
                    end
                end
                FETCH: begin
                    ir    <= imem[pc];
                    state <= EXEC;
                end
                EXEC: begin
                    if (retired != '1)
                        retired <= retired + 1'b1;
                    state <= FETCH;
                    pc    <= pc + 1'b1;
                    case (opcode)
                        OP_HLT: begin
                            pc     <= pc;
                            state  <= HALTED;
                            ready  <= 1'b1;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                        OP_SKZ: pc <= pc + (zero ? ADDR_W'(2) : ADDR_W'(1));
                        OP_ADD: {carry, acc} <= sum;
                        OP_AND: acc <= acc & mem_word;
                        OP_XOR: acc <= acc ^ mem_word;
                        OP_LDA: acc <= mem_word;
                        OP_STO: dmem[operand] <= acc;
                        OP_JMP: pc <= operand;
                        default: ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: scoreboard checks results at every halt
// of the default instance; a second instance covers DATA_W=16, ADDR_W=6.
module tb_acc_cpu_core;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---------------- default instance (8/5/16) ----------------
    logic        reset, start;
    logic [4:0]  dbg_addr;
    logic [7:0]  dbg_data, acc, ir;
    logic [4:0]  pc;
    logic        carry, zero, busy, halted;
    logic [15:0] retired;

    acc_cpu_core_if #(.ADDR_W(5)) ld ();

    acc_cpu_core #(.DATA_W(8), .ADDR_W(5), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .ld(ld),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc(pc), .ir(ir),
        .acc(acc), .carry(carry), .zero(zero), .busy(busy),
        .halted(halted), .retired(retired)
    );

    // ---------------- sweep instance (16/6/16) ----------------
    logic        reset16, start16;
    logic [5:0]  dbg_addr16, pc16;
    logic [15:0] dbg_data16, acc16, retired16;
    logic [8:0]  ir16;
    logic        carry16, zero16, busy16, halted16;

    acc_cpu_core_if #(.ADDR_W(6)) ld16 ();

    acc_cpu_core #(.DATA_W(16), .ADDR_W(6), .CNT_W(16)) dut16 (
        .clock(clock), .reset(reset16), .start(start16), .ld(ld16),
        .dbg_addr(dbg_addr16), .dbg_data(dbg_data16), .pc(pc16), .ir(ir16),
        .acc(acc16), .carry(carry16), .zero(zero16), .busy(busy16),
        .halted(halted16), .retired(retired16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          id;
        logic [7:0]  acc;
        logic        carry;
        logic [4:0]  pc;
        logic [15:0] retired;
        logic [7:0]  dbg;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic halted_prev = 1'b0;

    task automatic push_exp(input int id, input logic [7:0] a, input logic c,
                            input logic [4:0] p, input logic [15:0] r, input logic [7:0] d);
        exp_t e;
        e.id = id; e.acc = a; e.carry = c; e.pc = p; e.retired = r; e.dbg = d;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (halted && !halted_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_halt", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check($sformatf("sb%0d_acc", cur.id), {24'd0, acc}, {24'd0, cur.acc});
                    check($sformatf("sb%0d_carry", cur.id), {31'd0, carry}, {31'd0, cur.carry});
                    check($sformatf("sb%0d_zero", cur.id), {31'd0, zero}, {31'd0, cur.acc == 8'h00});
                    check($sformatf("sb%0d_pc", cur.id), {27'd0, pc}, {27'd0, cur.pc});
                    check($sformatf("sb%0d_retired", cur.id), {16'd0, retired}, {16'd0, cur.retired});
                    check($sformatf("sb%0d_dbg", cur.id), {24'd0, dbg_data}, {24'd0, cur.dbg});
                    check($sformatf("sb%0d_busy", cur.id), {31'd0, busy}, 32'd0);
                end
            end
            halted_prev = halted;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input logic sel, input logic [4:0] addr, input logic [7:0] data);
        int n;
        @(negedge clock);
        ld.load_valid = 1'b1; ld.load_sel = sel; ld.load_addr = addr; ld.load_data = data;
        n = 0;
        while (!ld.load_ready && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) check("load_timeout", 32'd1, 32'd0);
        @(posedge clock); #1;
        ld.load_valid = 1'b0;
    endtask

    task automatic load16(input logic sel, input logic [5:0] addr, input logic [8:0] data);
        int n;
        @(negedge clock);
        ld16.load_valid = 1'b1; ld16.load_sel = sel; ld16.load_addr = addr; ld16.load_data = data;
        n = 0;
        while (!ld16.load_ready && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) check("load16_timeout", 32'd1, 32'd0);
        @(posedge clock); #1;
        ld16.load_valid = 1'b0;
    endtask

    // Cycles are counted from the edge that samples start.
    task automatic run(input int budget, output int cycles);
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        cycles = 0;
        while (!halted && cycles < budget) begin @(posedge clock); #1; cycles++; end
        @(negedge clock); @(negedge clock);
    endtask

    task automatic run16(input int budget, output int cycles);
        @(negedge clock); start16 = 1'b1;
        @(posedge clock); #1; start16 = 1'b0;
        cycles = 0;
        while (!halted16 && cycles < budget) begin @(posedge clock); #1; cycles++; end
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic load_basic();
        load(1'b0, 5'd0, 8'hBB);
        load(1'b0, 5'd1, 8'h5C);
        load(1'b0, 5'd2, 8'hDD);
        load(1'b0, 5'd3, 8'h00);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int n;
        reset = 1'b1; start = 1'b0; dbg_addr = 5'h1D;
        ld.load_valid = 1'b0; ld.load_sel = 1'b0; ld.load_addr = '0; ld.load_data = '0;
        reset16 = 1'b1; start16 = 1'b0; dbg_addr16 = '0;
        ld16.load_valid = 1'b0; ld16.load_sel = 1'b0; ld16.load_addr = '0; ld16.load_data = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0; reset16 = 1'b0;

        // reset state
        check("rst_ready", {31'd0, ld.load_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_pc", {27'd0, pc}, 32'd0);
        check("rst_acc", {24'd0, acc}, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);

        // basic program: 0xFF + 0x02 -> 0x01 with carry
        load_basic();
        load(1'b1, 5'h1B, 8'hFF);
        load(1'b1, 5'h1C, 8'h02);
        dbg_addr = 5'h1D;
        push_exp(1, 8'h01, 1'b1, 5'd3, 16'd4, 8'h01);
        run(50, cyc);
        check("basic_cycles", cyc, 32'd8);

        // reset clears dmem and acc
        pulse_reset();
        check("rst2_dmem", {24'd0, dbg_data}, 32'd0);
        check("rst2_acc", {24'd0, acc}, 32'd0);

        // SKZ taken with acc=0
        load(1'b0, 5'd0, 8'h20);
        load(1'b0, 5'd1, 8'hE1);
        load(1'b0, 5'd2, 8'h00);
        push_exp(2, 8'h00, 1'b0, 5'd2, 16'd2, 8'h00);
        run(50, cyc);
        check("skz_taken_cycles", cyc, 32'd4);

        // preload acc=0xFF, then SKZ not taken loops at pc 1
        load(1'b1, 5'h1B, 8'hFF);
        load(1'b0, 5'd0, 8'hBB);
        load(1'b0, 5'd1, 8'h00);
        dbg_addr = 5'h1B;
        push_exp(3, 8'hFF, 1'b0, 5'd1, 16'd2, 8'hFF);
        run(50, cyc);
        load(1'b0, 5'd0, 8'h20);
        load(1'b0, 5'd1, 8'hE1);
        load(1'b0, 5'd2, 8'h00);
        run(100, cyc);
        check("loop_no_halt", {31'd0, halted}, 32'd0);
        check("loop_pc", {27'd0, pc}, 32'd1);
        check("loop_busy", {31'd0, busy}, 32'd1);
        pulse_reset();
        check("loop_rst_ready", {31'd0, ld.load_ready}, 32'd1);

        // pc wrap: SKZ, JMP 31, ADD at 31 -> pc 0, SKZ not taken, HLT at 1
        load(1'b1, 5'h1E, 8'h03);
        load(1'b0, 5'd0, 8'h20);
        load(1'b0, 5'd1, 8'h00);
        load(1'b0, 5'd2, 8'hFF);
        load(1'b0, 5'd31, 8'h5E);
        dbg_addr = 5'h1E;
        push_exp(4, 8'h03, 1'b0, 5'd1, 16'd5, 8'h03);
        run(50, cyc);
        check("wrap_cycles", cyc, 32'd10);

        // load gating while busy; write lands on first edge after HALTED
        load_basic();
        load(1'b1, 5'h1B, 8'hFF);
        load(1'b1, 5'h1C, 8'h02);
        dbg_addr = 5'h05;
        push_exp(5, 8'h01, 1'b1, 5'd3, 16'd4, 8'h00);
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        ld.load_valid = 1'b1; ld.load_sel = 1'b1; ld.load_addr = 5'h05; ld.load_data = 8'h77;
        cyc = 0;
        while (!halted && cyc < 50) begin
            @(negedge clock);
            check("gate_ready", {31'd0, ld.load_ready}, 32'd0);
            check("gate_dmem", {24'd0, dbg_data}, 32'd0);
            @(posedge clock); #1; cyc++;
        end
        check("gate_cycles", cyc, 32'd8);
        @(negedge clock);
        check("gate_ready_halted", {31'd0, ld.load_ready}, 32'd1);
        @(posedge clock); #1; ld.load_valid = 1'b0;
        @(negedge clock);
        check("gate_land", {24'd0, dbg_data}, 32'h77);
        check("gate_still_halted", {31'd0, halted}, 32'd1);

        // simultaneous start + load in IDLE
        pulse_reset();
        dbg_addr = 5'h06;
        @(negedge clock);
        start = 1'b1;
        ld.load_valid = 1'b1; ld.load_sel = 1'b1; ld.load_addr = 5'h06; ld.load_data = 8'h5A;
        @(posedge clock); #1;
        start = 1'b0; ld.load_valid = 1'b0;
        @(negedge clock);
        check("simul_busy", {31'd0, busy}, 32'd0);
        check("simul_ready", {31'd0, ld.load_ready}, 32'd1);
        check("simul_dmem", {24'd0, dbg_data}, 32'h5A);

        // async reset during EXEC of STO
        load(1'b1, 5'h1B, 8'hFF);
        load(1'b1, 5'h1C, 8'h02);
        dbg_addr = 5'h1D;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        n = 0;
        do begin @(negedge clock); n++; end while (ir != 8'hDD && n < 50);
        check("sto_reached", {24'd0, ir}, 32'hDD);
        reset = 1'b1;
        #1;
        check("mid_rst_acc", {24'd0, acc}, 32'd0);
        check("mid_rst_pc", {27'd0, pc}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        check("mid_rst_dmem", {24'd0, dbg_data}, 32'd0);
        @(negedge clock); reset = 1'b0;
        check("mid_rst_ready", {31'd0, ld.load_ready}, 32'd1);
        load(1'b1, 5'h1B, 8'hFF);
        load(1'b1, 5'h1C, 8'h02);
        push_exp(6, 8'h01, 1'b1, 5'd3, 16'd4, 8'h01);
        run(50, cyc);
        check("rerun_cycles", cyc, 32'd8);

        // DATA_W=16: doubling 0x100 eight times overflows to 0 with carry
        load16(1'b1, 6'h3E, 9'h100);
        load16(1'b0, 6'd0, 9'h17E);
        load16(1'b0, 6'd1, 9'h1BF);
        load16(1'b0, 6'd2, 9'h0BF);
        load16(1'b0, 6'd3, 9'h040);
        load16(1'b0, 6'd4, 9'h1C1);
        load16(1'b0, 6'd5, 9'h000);
        dbg_addr16 = 6'h3F;
        run16(200, cyc);
        check("w16_halted", {31'd0, halted16}, 32'd1);
        check("w16_cycles", cyc, 32'd66);
        check("w16_acc", {16'd0, acc16}, 32'd0);
        check("w16_carry", {31'd0, carry16}, 32'd1);
        check("w16_zero", {31'd0, zero16}, 32'd1);
        check("w16_pc", {26'd0, pc16}, 32'd5);
        check("w16_retired", {16'd0, retired16}, 32'd33);
        check("w16_dbg", {16'd0, dbg_data16}, 32'h8000);

        // ADDR_W=6: JMP 63, LDA at 63 wraps pc to 0
        @(negedge clock); reset16 = 1'b1;
        @(negedge clock); reset16 = 1'b0;
        load16(1'b1, 6'h3E, 9'h005);
        load16(1'b0, 6'd0, 9'h040);
        load16(1'b0, 6'd1, 9'h000);
        load16(1'b0, 6'd2, 9'h1FF);
        load16(1'b0, 6'd63, 9'h17E);
        run16(100, cyc);
        check("w16wrap_halted", {31'd0, halted16}, 32'd1);
        check("w16wrap_cycles", cyc, 32'd10);
        check("w16wrap_pc", {26'd0, pc16}, 32'd1);
        check("w16wrap_acc", {16'd0, acc16}, 32'd5);
        check("w16wrap_retired", {16'd0, retired16}, 32'd5);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
